// File: rtl/ysyx_23060025_icache_pkg.sv
// Shared definitions for the instruction cache: geometry defaults, FSM state
// type and the AXI encodings used by the refill master.
package ysyx_23060025_icache_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH  = 32;
  localparam int unsigned ICACHE_DATA_WIDTH  = 32;
  localparam int unsigned ICACHE_OFFSET_BITS = 4;
  localparam int unsigned ICACHE_INDEX_BITS  = 4;

  typedef enum logic [1:0] {
    ICACHE_IDLE    = 2'd0,
    ICACHE_LOOKUP  = 2'd1,
    ICACHE_MISS_AR = 2'd2,
    ICACHE_MISS_R  = 2'd3
  } icache_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_23060025_icache_array.sv
// Direct-mapped icache storage: per-line valid bit, tag and data words.
// One combinational read port, one word write port, a tag+valid write port
// and a flash clear of every valid bit.
module ysyx_23060025_icache_array #(
  parameter int unsigned TAG_BITS   = 24,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WORD_BITS  = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flash_clear_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  input  logic [WORD_BITS-1:0]  rd_word_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  wr_en_i,
  input  logic [WORD_BITS-1:0]  wr_word_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  tag_we_i,
  input  logic [TAG_BITS-1:0]   tag_i,
  input  logic                  valid_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned SLOTS = 1 << (INDEX_BITS + WORD_BITS);

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [SLOTS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];

  // Valid bits: cleared by reset or flash clear, written with the tag on line fill
  always_ff @(posedge clock) begin
    if (reset || flash_clear_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_idx_i] <= valid_i;
    end
  end

  // Tag storage, written once per refill on the last beat
  always_ff @(posedge clock) begin
    if (tag_we_i) begin
      tag_q[wr_idx_i] <= tag_i;
    end
  end

  // Data storage, one word per accepted refill beat
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped instruction cache between the IFU and the AXI arbiter.
// Hits answer in the LOOKUP cycle; misses refill a full line with an AXI4
// INCR burst and re-run the lookup. Optional performance counters are built
// when YSYX_23060025_ICACHE_PERF_EN is defined.
module ysyx_23060025_icache
  import ysyx_23060025_icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ICACHE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = ICACHE_DATA_WIDTH,
  parameter int unsigned OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int unsigned INDEX_BITS  = ICACHE_INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ifu_psel_i,
  input  logic [ADDR_WIDTH-1:0] ifu_paddr_i,
  output logic                  ifu_pready_o,
  output logic [DATA_WIDTH-1:0] ifu_prdata_o,
  input  logic                  fence_i_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i
);

  localparam int unsigned WORD_BITS = OFFSET_BITS - 2;
  localparam int unsigned WORDS     = 1 << WORD_BITS;
  localparam int unsigned TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

  icache_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:2] req_addr_q, req_addr_d;
  logic [WORD_BITS-1:0]  beat_q, beat_d;
  logic                  beat_ovf_q, beat_ovf_d;
  logic                  resp_err_q, resp_err_d;
  logic                  fence_pend_q, fence_pend_d;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [WORD_BITS-1:0]  req_word;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;

  logic                  flash_clear;
  logic                  wr_en;
  logic                  tag_we;
  logic                  valid_wr;

  logic                  unused_paddr_lsb;

  assign unused_paddr_lsb = ^ifu_paddr_i[1:0];

  assign req_tag  = req_addr_q[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
  assign req_idx  = req_addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign req_word = req_addr_q[OFFSET_BITS-1:2];

  assign hit = rd_valid && (rd_tag == req_tag);

  assign arlen_o   = 8'(WORDS - 1);
  assign arsize_o  = AXI_SIZE_4B;
  assign arburst_o = AXI_BURST_INCR;

  ysyx_23060025_icache_array #(
    .TAG_BITS   (TAG_BITS),
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WORD_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clock         (clock),
    .reset         (reset),
    .flash_clear_i (flash_clear),
    .rd_idx_i      (req_idx),
    .rd_word_i     (req_word),
    .rd_valid_o    (rd_valid),
    .rd_tag_o      (rd_tag),
    .rd_data_o     (rd_data),
    .wr_idx_i      (req_idx),
    .wr_en_i       (wr_en),
    .wr_word_i     (beat_q),
    .wr_data_i     (rdata_i),
    .tag_we_i      (tag_we),
    .tag_i         (req_tag),
    .valid_i       (valid_wr)
  );

  // State, request address, refill bookkeeping and pending fence
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ICACHE_IDLE;
      req_addr_q   <= '0;
      beat_q       <= '0;
      beat_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      beat_q       <= beat_d;
      beat_ovf_q   <= beat_ovf_d;
      resp_err_q   <= resp_err_d;
      fence_pend_q <= fence_pend_d;
    end
  end

  // Next-state, IFU response, AXI master outputs and array write controls.
  // A fence seen outside IDLE is parked and applied in the first IDLE cycle,
  // so an in-flight lookup still completes against the old contents.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    beat_d       = beat_q;
    beat_ovf_d   = beat_ovf_q;
    resp_err_d   = resp_err_q;
    fence_pend_d = fence_pend_q | fence_i_i;
    flash_clear  = 1'b0;
    ifu_pready_o = 1'b0;
    ifu_prdata_o = '0;
    arvalid_o    = 1'b0;
    araddr_o     = '0;
    rready_o     = 1'b0;
    wr_en        = 1'b0;
    tag_we       = 1'b0;
    valid_wr     = 1'b0;

    unique case (state_q)
      ICACHE_IDLE: begin
        fence_pend_d = 1'b0;
        flash_clear  = fence_i_i | fence_pend_q;
        if (ifu_psel_i) begin
          req_addr_d = ifu_paddr_i[ADDR_WIDTH-1:2];
          state_d    = ICACHE_LOOKUP;
        end
      end
      ICACHE_LOOKUP: begin
        if (hit) begin
          ifu_pready_o = 1'b1;
          ifu_prdata_o = rd_data;
          state_d      = ICACHE_IDLE;
        end else begin
          state_d = ICACHE_MISS_AR;
        end
      end
      ICACHE_MISS_AR: begin
        arvalid_o = 1'b1;
        araddr_o  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
        if (arready_i) begin
          beat_d     = '0;
          beat_ovf_d = 1'b0;
          resp_err_d = 1'b0;
          state_d    = ICACHE_MISS_R;
        end
      end
      ICACHE_MISS_R: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          wr_en  = 1'b1;
          beat_d = beat_q + WORD_BITS'(1);
          if (beat_q == '1) begin
            beat_ovf_d = 1'b1;
          end
          if (rresp_i != AXI_RESP_OKAY) begin
            resp_err_d = 1'b1;
          end
          if (rlast_i) begin
            // Valid only for exactly WORDS beats, all OKAY.
            tag_we   = 1'b1;
            valid_wr = !beat_ovf_q && (beat_q == '1) && !resp_err_q &&
                       (rresp_i == AXI_RESP_OKAY);
            state_d  = ICACHE_LOOKUP;
          end
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

`ifdef YSYX_23060025_ICACHE_PERF_EN
  logic [63:0] perf_hit_cnt_q;
  logic [63:0] perf_miss_cnt_q;
  logic [63:0] perf_refill_cycle_cnt_q;

  // Hit/miss counted at each LOOKUP exit; refill cycles while in MISS_*
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hit_cnt_q          <= '0;
      perf_miss_cnt_q         <= '0;
      perf_refill_cycle_cnt_q <= '0;
    end else begin
      if (state_q == ICACHE_LOOKUP) begin
        if (hit) begin
          perf_hit_cnt_q <= perf_hit_cnt_q + 64'd1;
        end else begin
          perf_miss_cnt_q <= perf_miss_cnt_q + 64'd1;
        end
      end
      if ((state_q == ICACHE_MISS_AR) || (state_q == ICACHE_MISS_R)) begin
        perf_refill_cycle_cnt_q <= perf_refill_cycle_cnt_q + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Bench for ysyx_23060025_icache: acts as IFU and AXI slave, predicts
// hit/miss and refill counts from a line-level cache model and a
// computed memory image.
module tb_ysyx_23060025_icache;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_psel_i;
  logic [31:0] ifu_paddr_i;
  logic        ifu_pready_o;
  logic [31:0] ifu_prdata_o;
  logic        fence_i_i;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_valid;
  logic [23:0] model_tag [16];

  always #5 clock = ~clock;

  ysyx_23060025_icache dut (
    .clock        (clock),
    .reset        (reset),
    .ifu_psel_i   (ifu_psel_i),
    .ifu_paddr_i  (ifu_paddr_i),
    .ifu_pready_o (ifu_pready_o),
    .ifu_prdata_o (ifu_prdata_o),
    .fence_i_i    (fence_i_i),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .araddr_o     (araddr_o),
    .arlen_o      (arlen_o),
    .arsize_o     (arsize_o),
    .arburst_o    (arburst_o),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .rlast_i      (rlast_i)
  );

  // Memory image: line 0x8000_0000 holds 0x11,0x22,0x33,0x44; elsewhere a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h8000000) return 32'h11 * (32'(w[3:2]) + 32'd1);
    return (w * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One IFU fetch. fence_mode: 0 none, 1 fence with psel in IDLE,
  // 2 fence pulse during the second beat of the first refill.
  // err_beat >= 0 puts SLVERR on that beat of the first refill.
  task automatic fetch(input logic [31:0] addr, input int ar_delay,
                       input int err_beat, input int fence_mode);
    int          idx;
    logic [23:0] tg;
    logic [31:0] line_addr;
    logic        exp_hit;
    logic        got;
    logic        fence_sent;
    logic [31:0] rd;
    int          cycles, n_ar, b, ar_wait, exp_ar;

    idx        = int'(addr[7:4]);
    tg         = addr[31:8];
    line_addr  = {addr[31:4], 4'h0};
    got        = 1'b0;
    fence_sent = 1'b0;
    rd         = '0;
    cycles     = 0;
    n_ar       = 0;
    b          = 0;
    ar_wait    = 0;

    if (fence_mode == 1) model_valid = '0;
    exp_hit = model_valid[idx] && (model_tag[idx] == tg);

    ifu_psel_i  = 1'b1;
    ifu_paddr_i = addr;
    fence_i_i   = (fence_mode == 1);

    while (!got && cycles < 300) begin
      @(posedge clock); #1;
      cycles++;
      fence_i_i = 1'b0;
      if (rvalid_i) begin
        b++;
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rresp_i  = 2'b00;
      end
      if (arready_i) begin
        arready_i = 1'b0;
        n_ar++;
        b       = 0;
        ar_wait = 0;
      end
      if (ifu_pready_o) begin
        got = 1'b1;
        rd  = ifu_prdata_o;
      end else if (arvalid_o) begin
        check("araddr", araddr_o, line_addr);
        check("ar_attr", {arlen_o, arsize_o, arburst_o}, {8'd3, 3'b010, 2'b01});
        if (ar_wait < ar_delay) ar_wait++;
        else arready_i = 1'b1;
      end else if (rready_o && b < 4) begin
        rvalid_i = 1'b1;
        rdata_i  = mem_word(line_addr + 32'(4 * b));
        rresp_i  = (n_ar == 1 && b == err_beat) ? 2'b10 : 2'b00;
        rlast_i  = (b == 3);
        if (fence_mode == 2 && n_ar == 1 && b == 1) begin
          fence_i_i  = 1'b1;
          fence_sent = 1'b1;
        end
      end
    end

    ifu_psel_i = 1'b0;
    check("fetch_done", 32'(got), 32'd1);
    check("prdata", rd, mem_word(addr));
    exp_ar = exp_hit ? 0 : ((err_beat >= 0 && err_beat < 4) ? 2 : 1);
    check("ar_count", n_ar, exp_ar);
    // pready seen one edge after psel was first sampled: 2-cycle hit latency
    if (exp_hit) check("hit_latency", cycles, 1);
    @(posedge clock); #1;
    check("pready_single", 32'(ifu_pready_o), 32'd0);

    model_valid[idx] = 1'b1;
    model_tag[idx]   = tg;
    if (fence_sent) model_valid = '0;
  endtask

  initial begin
    logic [31:0] ra;
    int          r, eb, fm;
    logic        seen;

    reset       = 1'b1;
    ifu_psel_i  = 1'b0;
    ifu_paddr_i = '0;
    fence_i_i   = 1'b0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rdata_i     = '0;
    rresp_i     = 2'b00;
    rlast_i     = 1'b0;
    model_valid = '0;
    for (int i = 0; i < 16; i++) model_tag[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_pready", 32'(ifu_pready_o), 32'd0);
    check("rst_prdata", ifu_prdata_o, 32'd0);
    check("rst_arvalid", 32'(arvalid_o), 32'd0);
    check("rst_rready", 32'(rready_o), 32'd0);
    check("rst_araddr", araddr_o, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Cold miss then hits on the rest of the line
    fetch(32'h8000_0000, 0, -1, 0);
    fetch(32'h8000_0004, 0, -1, 0);
    fetch(32'h8000_0008, 0, -1, 0);
    fetch(32'h8000_000C, 0, -1, 0);

    // Conflict on index 0
    fetch(32'h8000_0100, 0, -1, 0);
    fetch(32'h8000_0000, 0, -1, 0);

    // Slow AR handshake
    fetch(32'h8000_0020, 5, -1, 0);

    // Fence during refill: fetch completes, then everything is invalid
    fetch(32'h8000_0010, 0, -1, 2);
    fetch(32'h8000_0000, 0, -1, 0);

    // Error response on beat 2 forces a retried refill
    fetch(32'h8000_0030, 0, 2, 0);
    fetch(32'h8000_0034, 0, -1, 0);

    // Fence together with psel in IDLE: clear wins, lookup misses
    fetch(32'h8000_0034, 0, -1, 1);

    // Reset in the middle of a refill
    ifu_psel_i  = 1'b1;
    ifu_paddr_i = 32'h8000_0250;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (arvalid_o) begin
        seen = 1'b1;
        arready_i = 1'b1;
      end
    end
    check("rstmid_ar_seen", 32'(seen), 32'd1);
    @(posedge clock); #1;
    arready_i = 1'b0;
    check("rstmid_rready", 32'(rready_o), 32'd1);
    reset = 1'b1;
    ifu_psel_i = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rstmid_arvalid_drop", 32'(arvalid_o), 32'd0);
    check("rstmid_rready_drop", 32'(rready_o), 32'd0);
    model_valid = '0;
    fetch(32'h8000_0034, 0, -1, 0);

    // Randomized fetch mix over a few tags
    for (int n = 0; n < 60; n++) begin
      ra = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 8) +
           (32'($urandom_range(0, 15)) << 4) + (32'($urandom_range(0, 3)) << 2);
      eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      r  = int'($urandom_range(0, 9));
      fm = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      fetch(ra, int'($urandom_range(0, 3)), eb, fm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
